pwm_seno_multicanal: RTL

Multi-channel sine-modulated PWM generator and parametrised successor of the single-channel sine PWM.
- One shared R-bit carrier counter.
- One shared sine-table index that advances every n_div carrier frames.
- CH outputs, each offset by a programmable phase step, for example 3-phase drive.
- Adds amplitude scaling, glitch-free duty updates at frame boundaries, shadowed n_div, enable, and status strobes.

---
 rtl/pwm_seno_multicanal.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pwm_seno_multicanal.sv
// Multi-channel sine-modulated PWM: one shared carrier counter and sine index,
// per-channel phase offset and amplitude scaling, duties reloaded only at frame ends.
module pwm_seno_multicanal #(
   parameter int R     = 6,
   parameter int NW    = 12,
   parameter int CH    = 3,
   parameter int DEPTH = 36,
   parameter int PW    = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [NW-1:0] n_div,
   input  logic [PW-1:0] phase_step,
   input  logic [R-1:0]  amp,
   output logic [CH-1:0] pwm_out,
   output logic [PW-1:0] idx,
   output logic          frame_tick,
   output logic          cycle_tick
);

   // round(63*(0.5+0.5*sin(2*pi*i/36))), tabulated for the default R=6, DEPTH=36
   localparam logic [5:0] SINE_TAB [36] = '{
      6'd32, 6'd37, 6'd42, 6'd47, 6'd52, 6'd56, 6'd59, 6'd61, 6'd63,
      6'd63, 6'd63, 6'd61, 6'd59, 6'd56, 6'd52, 6'd47, 6'd42, 6'd37,
      6'd32, 6'd26, 6'd21, 6'd16, 6'd11, 6'd7,  6'd4,  6'd2,  6'd0,
      6'd0,  6'd0,  6'd2,  6'd4,  6'd7,  6'd11, 6'd16, 6'd21, 6'd26
   };

   // Both operands are already < DEPTH, so one conditional subtract wraps the sum.
   function automatic logic [PW-1:0] mod_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
      logic [PW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
      return s[PW-1:0];
   endfunction

   function automatic logic [R-1:0] scale_duty(input logic [R-1:0] s, input logic [R-1:0] a);
      logic [2*R:0] p;
      p = {{(R+1){1'b0}}, s} * {{R{1'b0}}, ({1'b0, a} + (R+1)'(1))};
      return p[2*R-1:R];
   endfunction

   logic [R-1:0]  cnt_q;
   logic [NW-1:0] n_q;
   logic [NW-1:0] n_div_q;
   logic [PW-1:0] idx_q;
   logic [R-1:0]  duty_q [CH];
   logic [R-1:0]  duty_d [CH];
   logic [CH-1:0] pwm_q;
   logic          frame_tick_q;
   logic          cycle_tick_q;

   logic          frame_end;
   logic          intv_end;
   logic          idx_wrap;
   logic [PW-1:0] idx_adv;
   logic [PW-1:0] idx_d;
   logic [PW-1:0] ps_eff;
   logic [NW-1:0] n_div_eff;

   assign frame_end = en && (cnt_q == '1);
   assign intv_end  = frame_end && (({1'b0, n_q} + (NW+1)'(1)) >= {1'b0, n_div_q});
   assign idx_wrap  = (idx_q == PW'(DEPTH-1));
   assign idx_adv   = idx_wrap ? '0 : idx_q + PW'(1);
   assign idx_d     = intv_end ? idx_adv : idx_q;
   assign ps_eff    = (phase_step >= PW'(DEPTH)) ? '0 : phase_step;
   assign n_div_eff = (n_div == '0) ? NW'(1) : n_div;

   // Duties for the frame that starts after this edge, from the post-update index.
   always_comb begin
      logic [PW-1:0] ch_idx;
      ch_idx = idx_d;
      for (int k = 0; k < CH; k++) begin
         duty_d[k] = scale_duty(SINE_TAB[ch_idx], amp);
         ch_idx    = mod_add(ch_idx, ps_eff);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         n_q          <= '0;
         n_div_q      <= NW'(1);
         idx_q        <= '0;
         pwm_q        <= '0;
         frame_tick_q <= 1'b0;
         cycle_tick_q <= 1'b0;
         for (int k = 0; k < CH; k++) duty_q[k] <= '0;
      end else if (!en) begin
         cnt_q        <= '0;
         n_q          <= '0;
         n_div_q      <= n_div_eff;
         idx_q        <= '0;
         pwm_q        <= '0;
         frame_tick_q <= 1'b0;
         cycle_tick_q <= 1'b0;
         for (int k = 0; k < CH; k++) duty_q[k] <= '0;
      end else begin
         cnt_q        <= cnt_q + R'(1);
         frame_tick_q <= frame_end;
         cycle_tick_q <= intv_end && idx_wrap;
         for (int k = 0; k < CH; k++) pwm_q[k] <= (cnt_q < duty_q[k]);
         if (frame_end) begin
            if (intv_end) begin
               n_q     <= '0;
               idx_q   <= idx_adv;
               n_div_q <= n_div_eff;
            end else begin
               n_q <= n_q + NW'(1);
            end
            duty_q <= duty_d;
         end
      end
   end

   assign pwm_out    = pwm_q;
   assign idx        = idx_q;
   assign frame_tick = frame_tick_q;
   assign cycle_tick = cycle_tick_q;

endmodule
